// File: rtl/audio_nios_i2c_byte_master.sv
// Avalon-MM I2C byte engine: START, 8 data bits, ACK bit and STOP on open-drain SCL/SDA.
// Software sets up DATA and CMD; the engine sequences the quarter-period phases in hardware.
module audio_nios_i2c_byte_master #(
    parameter int CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    inout  wire         i2c_scl,
    inout  wire         i2c_sda
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QRELOAD = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] qcnt_q;

    logic [7:0] tx_byte, rx_byte;
    logic [4:0] cmd_q;
    logic       stop_q, is_write_q, is_read_q, nack_q, ack_err_q;
    logic       scl_hold_q, sda_hold_q;
    logic       scl_low, sda_low;

    logic wr_en, cmd_wr, cmd_go, tick, sda_in;
    logic unused_wd;

    assign unused_wd = ^writedata[31:8];
    assign wr_en  = chipselect & ~write_n;
    assign cmd_wr = wr_en & (address == 2'd1) & ~busy_q;
    assign cmd_go = cmd_wr & (|writedata[3:0]);
    assign tick   = busy_q & (qcnt_q == '0);
    assign sda_in = i2c_sda;

    assign i2c_scl = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
            bit_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
        end
    end

    // Quarter-period timer: idle value doubles as the reload, so a new command starts a full quarter.
    always_ff @(posedge clk) begin
        if (!reset_n || !busy_q || qcnt_q == '0)
            qcnt_q <= QRELOAD;
        else
            qcnt_q <= qcnt_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        if (state_q == S_IDLE) begin
            if (cmd_go) begin
                busy_d  = 1'b1;
                phase_d = 2'd0;
                bit_d   = 3'd0;
                if (writedata[0])
                    state_d = S_START;
                else if (writedata[2] | writedata[3])
                    state_d = S_BIT;
                else
                    state_d = S_STOP;
            end
        end else if (tick) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                case (state_q)
                    S_START: state_d = (is_write_q | is_read_q) ? S_BIT : (stop_q ? S_STOP : S_IDLE);
                    S_BIT: begin
                        if (bit_q == 3'd7) state_d = S_ACK;
                        else               bit_d   = bit_q + 3'd1;
                    end
                    S_ACK:   state_d = stop_q ? S_STOP : S_IDLE;
                    default: state_d = S_IDLE;
                endcase
                if (state_d == S_IDLE) busy_d = 1'b0;
            end
        end
    end

    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state_q)
            S_IDLE: begin
                scl_low = scl_hold_q;
                sda_low = sda_hold_q;
            end
            S_START: begin
                sda_low = (phase_q >= 2'd2);
                scl_low = (phase_q == 2'd3);
            end
            S_BIT: begin
                scl_low = (phase_q < 2'd2);
                sda_low = is_write_q & ~tx_byte[3'd7 - bit_q];
            end
            S_ACK: begin
                scl_low = (phase_q < 2'd2);
                sda_low = is_read_q & ~nack_q;
            end
            S_STOP: begin
                scl_low = (phase_q == 2'd0);
                sda_low = (phase_q < 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_byte    <= 8'h00;
            rx_byte    <= 8'h00;
            cmd_q      <= 5'd0;
            stop_q     <= 1'b0;
            is_write_q <= 1'b0;
            is_read_q  <= 1'b0;
            nack_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            scl_hold_q <= 1'b0;
            sda_hold_q <= 1'b0;
            readdata   <= 32'd0;
        end else begin
            if (wr_en && address == 2'd0 && !busy_q)
                tx_byte <= writedata[7:0];
            if (cmd_wr)
                cmd_q <= writedata[4:0];
            if (cmd_go) begin
                stop_q     <= writedata[1];
                is_write_q <= writedata[2];
                is_read_q  <= writedata[3] & ~writedata[2];
                nack_q     <= writedata[4];
                if (writedata[2]) ack_err_q <= 1'b0;
            end
            // SDA is sampled on the tick that ends q2, while SCL is high.
            if (tick && phase_q == 2'd2) begin
                if (state_q == S_BIT && is_read_q)
                    rx_byte <= {rx_byte[6:0], sda_in};
                if (state_q == S_ACK && is_write_q)
                    ack_err_q <= sda_in;
            end
            // Without STOP the bus is parked: SCL low, SDA at its last driven level.
            if (tick && phase_q == 2'd3 && state_d == S_IDLE) begin
                scl_hold_q <= (state_q != S_STOP);
                sda_hold_q <= (state_q != S_STOP) & sda_low;
            end
            case (address)
                2'd0:    readdata <= {24'd0, rx_byte};
                2'd1:    readdata <= {27'd0, cmd_q};
                2'd2:    readdata <= {30'd0, ack_err_q, busy_q};
                default: readdata <= 32'd0;
            endcase
        end
    end

endmodule
